banked_register_file: RTL and testbench
=======================================

// Module: banked_register_file
// PURPOSE
//  CPU register file with NUM_BANKS banks of general registers and per-bank SP; PC is shared.
//  Interrupt entry switches to the next bank; interrupt return restores the previous bank.
//  Two tri-state read buses (a, b) drive the CPU datapath; one write port.
//  Register DEPTH-2 is SP (post-inc/pre-dec) and register DEPTH-1 is PC (post-inc).
// PARAMETERS
//  WORD_SIZE  32            register/bus width
//  SEL_WIDTH  4             register select width
//  DEPTH      2**SEL_WIDTH  registers visible per bank (GP = DEPTH-2, plus SP and PC)
//  NUM_BANKS  2             banks, >=1; bank index width BANK_W = max(1,$clog2(NUM_BANKS))
//  SP_RESET   0             reset value of every bank's SP
//  PC_RESET   0             reset value of PC
// PORTS
//  clk          in   1          clock, all state updates on rising edge
//  rst          in   1          synchronous, active-high reset
//  a            out  WORD_SIZE  tri bus; driven when oe_a, else 'z
//  b            out  WORD_SIZE  tri bus; driven when oe_b, else 'z
//  in           in   WORD_SIZE  write data
//  oe_a / oe_b  in   1          output enable for a / b
//  ld           in   1          write in to reg sel_in at the next edge
//  sel_a/sel_b/sel_in  in  SEL_WIDTH  read/write select
//  post_inc_sp  in   1          SP <= SP+1 at edge
//  pre_dec_sp   in   1          SP reads as SP-1 this cycle; SP <= SP-1 at edge
//  post_inc_pc  in   1          PC <= PC+1 at edge
//  int_enter    in   1          push current bank, bank <= bank+1
//  int_return   in   1          pop bank
//  bank         out  BANK_W     current bank index
//  bank_fault   out  1          sticky push-overflow/pop-underflow flag
// BEHAVIOUR
//  Reset: clk and rst as named above; reset is synchronous, active-high, and dominates every other input.
//   All GP regs <= 0; every bank's SP <= SP_RESET; PC <= PC_RESET; bank <= 0.
//   Nesting depth <= 0; bank_fault <= 0; a/b stay combinational (high-Z unless oe).
//  Reads: combinational from the current bank.
//   GP regs and SP are banked; PC is shared by all banks.
//   Read-during-write returns the old value; the new value is visible the cycle after the edge.
//   sel_a == sel_b with both oe asserted: both buses show the same value.
//  SP read value: SP-1 when pre_dec_sp is asserted alone, else SP; applies to bus a and bus b.
//  Update priority per register: rst > ld > inc/dec.
//   ld to SP/PC in the same cycle as inc/dec: the loaded value wins and inc/dec is dropped.
//   pre_dec_sp and post_inc_sp together: SP unchanged, read value = SP; no fault.
//  Arithmetic: inc/dec are modulo 2**WORD_SIZE (0-1 -> all ones; all ones+1 -> 0); no flags.
//  Bank state: bank index plus nesting depth 0..NUM_BANKS-1; bank == depth always.
//   int_enter with depth < NUM_BANKS-1: bank/depth +1 at the edge.
//   int_enter with depth == NUM_BANKS-1: ignored and bank_fault <= 1.
//   int_return with depth > 0: bank/depth -1 at the edge.
//   int_return with depth == 0: ignored and bank_fault <= 1.
//   int_enter and int_return together: both ignored; no fault.
//   ld, inc and dec in a bank-switch cycle act on the old (current) bank.
//   Registers of an inactive bank hold their values.
//  NUM_BANKS == 1: int_enter/int_return never change bank and always set bank_fault.
//  bank_fault clears only on rst.
// TESTING
//  rst 1 cycle -> SP=SP_RESET, PC=PC_RESET, GP=0, bank=0, bank_fault=0, a/b=z with oe low.
//  ld r3=0xDEADBEEF, oe_a sel_a=3 same cycle -> a shows old 0; next cycle a=0xDEADBEEF.
//  SP=0x100: pre_dec_sp+oe_a -> a=0xFF, SP then 0xFF.
//   SP=0x100: post_inc_sp+oe_a -> a=0x100, SP then 0x101.
//   SP=0: pre_dec_sp -> SP=0xFFFFFFFF.
//  Bank 0 r1=5, int_enter, ld r1=9, int_return -> read r1=5.
//   PC incremented during bank 1 stays incremented after int_return.
//  NUM_BANKS=2: two int_enter -> bank=1, fault=1; then int_return x2 -> bank=0, fault still 1.
//  Simultaneous cycle: ld SP=0x40 with post_inc_sp and int_enter -> bank 0 SP=0x40, bank=1.
//   Mid-sequence rst -> everything back to reset values.

Source files
------------

// File: rtl/banked_register_file_if.sv
// Control/data bundle between the CPU sequencer and the banked register file.
// The master (sequencer) drives selects, enables, write data and the stack/PC
// and interrupt strobes; the slave (register file) reports the current bank
// and the sticky bank fault flag.
//   in, ld, sel_a/sel_b/sel_in, oe_a/oe_b  : read/write port control
//   post_inc_sp, pre_dec_sp, post_inc_pc   : stack pointer / PC strobes
//   int_enter, int_return                  : bank push / pop
//   bank, bank_fault                       : bank state back to the master
interface banked_register_file_if #(
    parameter int WORD_SIZE = 32,
    parameter int SEL_WIDTH = 4,
    parameter int BANK_W    = 1
);
    logic [WORD_SIZE-1:0] in;
    logic                 ld;
    logic                 oe_a;
    logic                 oe_b;
    logic [SEL_WIDTH-1:0] sel_a;
    logic [SEL_WIDTH-1:0] sel_b;
    logic [SEL_WIDTH-1:0] sel_in;
    logic                 post_inc_sp;
    logic                 pre_dec_sp;
    logic                 post_inc_pc;
    logic                 int_enter;
    logic                 int_return;
    logic [BANK_W-1:0]    bank;
    logic                 bank_fault;

    modport master (
        output in, ld, oe_a, oe_b, sel_a, sel_b, sel_in,
        output post_inc_sp, pre_dec_sp, post_inc_pc, int_enter, int_return,
        input  bank, bank_fault
    );

    modport slave (
        input  in, ld, oe_a, oe_b, sel_a, sel_b, sel_in,
        input  post_inc_sp, pre_dec_sp, post_inc_pc, int_enter, int_return,
        output bank, bank_fault
    );
endinterface

// File: rtl/banked_register_file.sv
// Banked CPU register file.
// NUM_BANKS copies of the general registers and SP, one shared PC. Interrupt
// entry moves to the next bank, interrupt return moves back; the bank index
// doubles as the nesting depth. Select DEPTH-2 is SP, DEPTH-1 is PC.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   rf        : control bundle (slave side), see banked_register_file_if
//   a, b      : tri-state read buses, driven only while oe_a / oe_b are high

// One bank: DEPTH-2 general registers plus this bank's SP. Only the active
// bank accepts writes and stack updates; inactive banks hold.
module banked_register_file_bank #(
    parameter int                   WORD_SIZE = 32,
    parameter int                   SEL_WIDTH = 4,
    parameter int                   DEPTH     = 2**SEL_WIDTH,
    parameter logic [WORD_SIZE-1:0] SP_RESET  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 act,
    input  logic                 ld,
    input  logic [SEL_WIDTH-1:0] sel_in,
    input  logic [WORD_SIZE-1:0] din,
    input  logic                 inc_sp,
    input  logic                 dec_sp,
    input  logic [SEL_WIDTH-1:0] sel_a,
    input  logic [SEL_WIDTH-1:0] sel_b,
    output logic [WORD_SIZE-1:0] rd_a,
    output logic [WORD_SIZE-1:0] rd_b
);
    localparam int                   GP_N   = DEPTH - 2;
    localparam logic [SEL_WIDTH-1:0] SP_SEL = SEL_WIDTH'(DEPTH - 2);

    logic [GP_N-1:0][WORD_SIZE-1:0] gp_q;
    logic [WORD_SIZE-1:0]           sp_q;
    logic [WORD_SIZE-1:0]           sp_rd;
    logic                           dec_only;
    logic                           inc_only;

    // inc and dec together cancel: no change, no pre-decrement on reads
    assign dec_only = dec_sp && !inc_sp;
    assign inc_only = inc_sp && !dec_sp;
    assign sp_rd    = dec_only ? sp_q - 1'b1 : sp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gp_q <= '0;
        end else if (act && ld && sel_in < SP_SEL) begin
            gp_q[sel_in] <= din;
        end
    end

    // a load to SP overrides any inc/dec in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= SP_RESET;
        end else if (act) begin
            if (ld && sel_in == SP_SEL)
                sp_q <= din;
            else if (inc_only)
                sp_q <= sp_q + 1'b1;
            else if (dec_only)
                sp_q <= sp_q - 1'b1;
        end
    end

    // PC selects fall through to gp_q here; the top overrides them
    assign rd_a = (sel_a == SP_SEL) ? sp_rd : gp_q[sel_a];
    assign rd_b = (sel_b == SP_SEL) ? sp_rd : gp_q[sel_b];
endmodule

module banked_register_file #(
    parameter int                   WORD_SIZE = 32,
    parameter int                   SEL_WIDTH = 4,
    parameter int                   DEPTH     = 2**SEL_WIDTH,
    parameter int                   NUM_BANKS = 2,
    parameter logic [WORD_SIZE-1:0] SP_RESET  = '0,
    parameter logic [WORD_SIZE-1:0] PC_RESET  = '0,
    parameter int                   BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    banked_register_file_if.slave rf,
    output logic [WORD_SIZE-1:0] a,
    output logic [WORD_SIZE-1:0] b
);
    localparam logic [SEL_WIDTH-1:0] PC_SEL    = SEL_WIDTH'(DEPTH - 1);
    localparam logic [BANK_W-1:0]    LAST_BANK = BANK_W'(NUM_BANKS - 1);

    logic [BANK_W-1:0]                   bank_q;
    logic                                fault_q;
    logic [WORD_SIZE-1:0]                pc_q;
    logic [NUM_BANKS-1:0][WORD_SIZE-1:0] bank_rd_a;
    logic [NUM_BANKS-1:0][WORD_SIZE-1:0] bank_rd_b;
    logic [WORD_SIZE-1:0]                rd_a;
    logic [WORD_SIZE-1:0]                rd_b;
    logic                                enter_only;
    logic                                return_only;

    generate
        for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
            banked_register_file_bank #(
                .WORD_SIZE (WORD_SIZE),
                .SEL_WIDTH (SEL_WIDTH),
                .DEPTH     (DEPTH),
                .SP_RESET  (SP_RESET)
            ) u_bank (
                .clk    (clk),
                .rst    (rst),
                .act    (bank_q == BANK_W'(g)),
                .ld     (rf.ld),
                .sel_in (rf.sel_in),
                .din    (rf.in),
                .inc_sp (rf.post_inc_sp),
                .dec_sp (rf.pre_dec_sp),
                .sel_a  (rf.sel_a),
                .sel_b  (rf.sel_b),
                .rd_a   (bank_rd_a[g]),
                .rd_b   (bank_rd_b[g])
            );
        end
    endgenerate

    // PC is shared across banks; a load beats the increment
    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= PC_RESET;
        else if (rf.ld && rf.sel_in == PC_SEL)
            pc_q <= rf.in;
        else if (rf.post_inc_pc)
            pc_q <= pc_q + 1'b1;
    end

    // Simultaneous enter and return cancel out without a fault. With a
    // single bank LAST_BANK is 0, so every enter/return faults.
    assign enter_only  = rf.int_enter && !rf.int_return;
    assign return_only = rf.int_return && !rf.int_enter;

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q  <= '0;
            fault_q <= 1'b0;
        end else if (enter_only) begin
            if (bank_q == LAST_BANK)
                fault_q <= 1'b1;
            else
                bank_q <= bank_q + 1'b1;
        end else if (return_only) begin
            if (bank_q == '0)
                fault_q <= 1'b1;
            else
                bank_q <= bank_q - 1'b1;
        end
    end

    assign rd_a = (rf.sel_a == PC_SEL) ? pc_q : bank_rd_a[bank_q];
    assign rd_b = (rf.sel_b == PC_SEL) ? pc_q : bank_rd_b[bank_q];

    assign a = rf.oe_a ? rd_a : {WORD_SIZE{1'bz}};
    assign b = rf.oe_b ? rd_b : {WORD_SIZE{1'bz}};

    assign rf.bank       = bank_q;
    assign rf.bank_fault = fault_q;
endmodule

// File: tb/tb_banked_register_file.sv
module tb_banked_register_file;
    localparam int          W     = 32;
    localparam int          SW    = 4;
    localparam int          DEPTH = 16;
    localparam int          NB    = 2;
    localparam int          BW    = 1;
    localparam logic [31:0] SPR   = 32'h0000_0100;
    localparam logic [31:0] PCR   = 32'h0000_0200;
    localparam logic [3:0]  SP    = 4'd14;
    localparam logic [3:0]  PC    = 4'd15;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a, b;
    int            n_checks = 0;
    int            n_pass   = 0;

    // reference model: a plain array view of the architectural state
    logic [31:0] m_gp [NB][DEPTH-2];
    logic [31:0] m_sp [NB];
    logic [31:0] m_pc;
    int          m_bank;
    bit          m_fault;

    banked_register_file_if #(.WORD_SIZE(W), .SEL_WIDTH(SW), .BANK_W(BW)) bus ();

    banked_register_file #(
        .WORD_SIZE (W),
        .SEL_WIDTH (SW),
        .DEPTH     (DEPTH),
        .NUM_BANKS (NB),
        .SP_RESET  (SPR),
        .PC_RESET  (PCR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus),
        .a   (a),
        .b   (b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [3:0] sel);
        if (sel == PC) return m_pc;
        if (sel == SP) return (bus.pre_dec_sp && !bus.post_inc_sp) ? m_sp[m_bank] - 32'd1 : m_sp[m_bank];
        return m_gp[m_bank][sel];
    endfunction

    task automatic m_edge();
        int tgt;
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                m_sp[i] = SPR;
                for (int j = 0; j < DEPTH-2; j++) m_gp[i][j] = '0;
            end
            m_pc = PCR; m_bank = 0; m_fault = 0;
        end else begin
            if (bus.ld) begin
                if (bus.sel_in == PC)      m_pc = bus.in;
                else if (bus.sel_in == SP) m_sp[m_bank] = bus.in;
                else                       m_gp[m_bank][bus.sel_in] = bus.in;
            end
            if (!(bus.ld && bus.sel_in == SP))
                m_sp[m_bank] = m_sp[m_bank] + 32'(bus.post_inc_sp) - 32'(bus.pre_dec_sp);
            if (!(bus.ld && bus.sel_in == PC) && bus.post_inc_pc)
                m_pc = m_pc + 32'd1;
            if (bus.int_enter != bus.int_return) begin
                tgt = m_bank + (bus.int_enter ? 1 : -1);
                if (tgt < 0 || tgt >= NB) m_fault = 1;
                else                      m_bank = tgt;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        rst = 0;
        bus.in = '0; bus.ld = 0; bus.oe_a = 0; bus.oe_b = 0;
        bus.sel_a = '0; bus.sel_b = '0; bus.sel_in = '0;
        bus.post_inc_sp = 0; bus.pre_dec_sp = 0; bus.post_inc_pc = 0;
        bus.int_enter = 0; bus.int_return = 0;
    endtask

    task automatic load(input logic [3:0] sel, input logic [31:0] v);
        idle(); bus.ld = 1; bus.sel_in = sel; bus.in = v; tick();
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); idle(); #1;
        n_checks++; if (bus.bank !== 1'b0) $display("FAIL reset_bank: got %h want 0", bus.bank); else n_pass++;
        n_checks++; if (bus.bank_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", bus.bank_fault); else n_pass++;
        // an undriven bus may resolve to z or to 0 depending on the simulator
        n_checks++; if (a !== {W{1'bz}} && a !== '0) $display("FAIL reset_a_hiz: got %h want z", a); else n_pass++;
        bus.oe_a = 1; bus.sel_a = SP; bus.oe_b = 1; bus.sel_b = PC; #1;
        n_checks++; if (a !== SPR) $display("FAIL reset_sp: got %h want %h", a, SPR); else n_pass++;
        n_checks++; if (b !== PCR) $display("FAIL reset_pc: got %h want %h", b, PCR); else n_pass++;
        bus.sel_a = 4'd5; #1;
        n_checks++; if (a !== 32'd0) $display("FAIL reset_gp: got %h want 0", a); else n_pass++;
        tick();
    endtask

    task automatic test_read_during_write();
        idle(); bus.ld = 1; bus.sel_in = 4'd3; bus.in = 32'hDEADBEEF;
        bus.oe_a = 1; bus.sel_a = 4'd3; #1;
        n_checks++; if (a !== 32'd0) $display("FAIL rdw_old: got %h want 0", a); else n_pass++;
        tick(); idle(); bus.oe_a = 1; bus.sel_a = 4'd3; bus.oe_b = 1; bus.sel_b = 4'd3; #1;
        n_checks++; if (a !== 32'hDEADBEEF) $display("FAIL rdw_new: got %h want deadbeef", a); else n_pass++;
        n_checks++; if (b !== 32'hDEADBEEF) $display("FAIL rdw_same_sel_b: got %h want deadbeef", b); else n_pass++;
        tick();
    endtask

    task automatic test_sp();
        load(SP, 32'h100);
        idle(); bus.pre_dec_sp = 1; bus.oe_a = 1; bus.sel_a = SP; #1;
        n_checks++; if (a !== 32'hFF) $display("FAIL sp_predec_read: got %h want ff", a); else n_pass++;
        tick(); idle(); bus.oe_a = 1; bus.sel_a = SP; #1;
        n_checks++; if (a !== 32'hFF) $display("FAIL sp_predec_after: got %h want ff", a); else n_pass++;
        load(SP, 32'h100);
        idle(); bus.post_inc_sp = 1; bus.oe_b = 1; bus.sel_b = SP; #1;
        n_checks++; if (b !== 32'h100) $display("FAIL sp_postinc_read: got %h want 100", b); else n_pass++;
        tick(); idle(); bus.oe_b = 1; bus.sel_b = SP; #1;
        n_checks++; if (b !== 32'h101) $display("FAIL sp_postinc_after: got %h want 101", b); else n_pass++;
        // inc and dec together: read and stored value unchanged
        idle(); bus.post_inc_sp = 1; bus.pre_dec_sp = 1; bus.oe_a = 1; bus.sel_a = SP; #1;
        n_checks++; if (a !== 32'h101) $display("FAIL sp_both_read: got %h want 101", a); else n_pass++;
        tick(); idle(); bus.oe_a = 1; bus.sel_a = SP; #1;
        n_checks++; if (a !== 32'h101) $display("FAIL sp_both_after: got %h want 101", a); else n_pass++;
        load(SP, 32'h0);
        idle(); bus.pre_dec_sp = 1; tick();
        idle(); bus.oe_a = 1; bus.sel_a = SP; #1;
        n_checks++; if (a !== 32'hFFFFFFFF) $display("FAIL sp_wrap: got %h want ffffffff", a); else n_pass++;
        load(SP, 32'hFFFFFFFF);
        idle(); bus.post_inc_sp = 1; tick();
        idle(); bus.oe_a = 1; bus.sel_a = SP; #1;
        n_checks++; if (a !== 32'h0) $display("FAIL sp_wrap_up: got %h want 0", a); else n_pass++;
        tick();
    endtask

    task automatic test_banks();
        load(4'd1, 32'd5);
        idle(); bus.int_enter = 1; tick();
        idle(); bus.oe_a = 1; bus.sel_a = 4'd1; #1;
        n_checks++; if (bus.bank !== 1'b1) $display("FAIL bank_enter: got %h want 1", bus.bank); else n_pass++;
        n_checks++; if (a !== 32'd0) $display("FAIL bank1_r1_fresh: got %h want 0", a); else n_pass++;
        load(4'd1, 32'd9);
        idle(); bus.post_inc_pc = 1; tick();
        idle(); bus.int_return = 1; tick();
        idle(); bus.oe_a = 1; bus.sel_a = 4'd1; bus.oe_b = 1; bus.sel_b = PC; #1;
        n_checks++; if (a !== 32'd5) $display("FAIL bank0_r1_kept: got %h want 5", a); else n_pass++;
        n_checks++; if (b !== PCR + 32'd1) $display("FAIL pc_shared: got %h want %h", b, PCR + 32'd1); else n_pass++;
        tick();
    endtask

    task automatic test_simultaneous();
        idle(); bus.ld = 1; bus.sel_in = SP; bus.in = 32'h40; bus.post_inc_sp = 1; bus.int_enter = 1; tick();
        idle(); bus.oe_a = 1; bus.sel_a = SP; #1;
        n_checks++; if (bus.bank !== 1'b1) $display("FAIL simul_bank: got %h want 1", bus.bank); else n_pass++;
        n_checks++; if (a !== SPR) $display("FAIL simul_bank1_sp: got %h want %h", a, SPR); else n_pass++;
        idle(); bus.int_return = 1; tick();
        idle(); bus.oe_a = 1; bus.sel_a = SP; #1;
        n_checks++; if (a !== 32'h40) $display("FAIL simul_bank0_sp: got %h want 40", a); else n_pass++;
        tick();
    endtask

    task automatic test_fault();
        idle(); bus.int_enter = 1; tick(); tick(); idle(); #1;
        n_checks++; if (bus.bank !== 1'b1) $display("FAIL ovf_bank: got %h want 1", bus.bank); else n_pass++;
        n_checks++; if (bus.bank_fault !== 1'b1) $display("FAIL ovf_fault: got %b want 1", bus.bank_fault); else n_pass++;
        bus.int_enter = 1; bus.int_return = 1; tick(); idle(); #1;
        n_checks++; if (bus.bank !== 1'b1) $display("FAIL both_bank: got %h want 1", bus.bank); else n_pass++;
        bus.int_return = 1; tick(); tick(); idle(); #1;
        n_checks++; if (bus.bank !== 1'b0) $display("FAIL unf_bank: got %h want 0", bus.bank); else n_pass++;
        n_checks++; if (bus.bank_fault !== 1'b1) $display("FAIL fault_sticky: got %b want 1", bus.bank_fault); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] exp_a, exp_b;
        for (int c = 0; c < 400; c++) begin
            idle();
            rst              = ($urandom_range(0, 59) == 0);
            bus.in           = $urandom;
            bus.ld           = $urandom_range(0, 1);
            bus.sel_in       = 4'($urandom);
            bus.oe_a         = $urandom_range(0, 3) != 0;
            bus.oe_b         = $urandom_range(0, 3) != 0;
            bus.sel_a        = ($urandom_range(0, 3) == 0) ? SP : 4'($urandom);
            bus.sel_b        = ($urandom_range(0, 3) == 0) ? PC : 4'($urandom);
            bus.post_inc_sp  = $urandom_range(0, 2) == 0;
            bus.pre_dec_sp   = $urandom_range(0, 2) == 0;
            bus.post_inc_pc  = $urandom_range(0, 2) == 0;
            bus.int_enter    = $urandom_range(0, 7) == 0;
            bus.int_return   = $urandom_range(0, 7) == 0;
            #1;
            exp_a = m_read(bus.sel_a);
            exp_b = m_read(bus.sel_b);
            if (bus.oe_a) begin
                n_checks++; if (a !== exp_a) $display("FAIL rnd_a c=%0d sel=%0d: got %h want %h", c, bus.sel_a, a, exp_a); else n_pass++;
            end
            if (bus.oe_b) begin
                n_checks++; if (b !== exp_b) $display("FAIL rnd_b c=%0d sel=%0d: got %h want %h", c, bus.sel_b, b, exp_b); else n_pass++;
            end
            n_checks++; if (bus.bank !== BW'(m_bank)) $display("FAIL rnd_bank c=%0d: got %h want %0d", c, bus.bank, m_bank); else n_pass++;
            n_checks++; if (bus.bank_fault !== m_fault) $display("FAIL rnd_fault c=%0d: got %b want %b", c, bus.bank_fault, m_fault); else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        load(4'd7, 32'h1234_5678);
        idle(); bus.int_enter = 1; tick(); tick();
        idle(); rst = 1; bus.ld = 1; bus.sel_in = 4'd7; bus.in = 32'hFFFF_FFFF; bus.post_inc_pc = 1; bus.int_enter = 1; tick();
        idle(); bus.oe_a = 1; bus.sel_a = 4'd7; bus.oe_b = 1; bus.sel_b = PC; #1;
        n_checks++; if (a !== 32'd0) $display("FAIL midrst_gp: got %h want 0", a); else n_pass++;
        n_checks++; if (b !== PCR) $display("FAIL midrst_pc: got %h want %h", b, PCR); else n_pass++;
        n_checks++; if (bus.bank !== 1'b0) $display("FAIL midrst_bank: got %h want 0", bus.bank); else n_pass++;
        n_checks++; if (bus.bank_fault !== 1'b0) $display("FAIL midrst_fault: got %b want 0", bus.bank_fault); else n_pass++;
        bus.sel_a = SP; #1;
        n_checks++; if (a !== SPR) $display("FAIL midrst_sp: got %h want %h", a, SPR); else n_pass++;
        tick();
    endtask

    initial begin
        idle();
        #1;
        test_reset();
        test_read_during_write();
        test_sp();
        test_banks();
        test_simultaneous();
        test_fault();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
